pipelined_sum_tree: RTL

- Parametrised, pipelined N-input summation block: successor to the fixed 16x16-bit single-cycle adder.
- Reduces NUM_IN unsigned words through a registered binary adder tree, one level per stage.
- Optionally accumulates successive tree results across a multi-beat frame.
- Sits between the NoC packet unpacker (producer) and the result-return path (consumer), with valid/ready handshakes on both sides.

---
 rtl/pipelined_sum_tree.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipelined_sum_tree.sv
// Pipelined NUM_IN-word unsigned adder tree with multi-beat frame accumulation.
// Define SUM_TREE_SAT_EN to clamp the frame sum at its maximum on overflow instead of wrapping.
module pipelined_sum_tree #(
  parameter int unsigned NUM_IN = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 4,
  parameter int unsigned CNT_W  = 8,
  localparam int unsigned LEVELS = $clog2(NUM_IN),
  localparam int unsigned TREE_W = DATA_W + LEVELS,
  localparam int unsigned OUT_W  = TREE_W + ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [OUT_W-1:0]         out_sum,
  output logic [CNT_W-1:0]         out_beats,
  output logic                     out_ovf,
  output logic                     out_valid,
  input  logic                     out_ready
);

  // All tree levels live in one flat vector: level k starts at node 2*NUM_IN - 2*(NUM_IN>>k),
  // so level 0 holds the registered input words and the root sits at node 2*NUM_IN-2.
  localparam int unsigned NODES = 2 * NUM_IN - 1;
  localparam int unsigned ROOT  = 2 * NUM_IN - 2;

  logic                    w_stall;
  logic [NODES*TREE_W-1:0] r_tree;
  logic [LEVELS:0]         r_vld;
  logic [LEVELS:0]         r_lst;
  logic [TREE_W-1:0]       w_root;

  logic [OUT_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sticky;
  logic [OUT_W:0]          w_add;
  logic [OUT_W-1:0]        w_acc_nxt;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_ovf;

  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_tree[gi*TREE_W +: TREE_W] <= '0;
      end else if (!w_stall) begin
        r_tree[gi*TREE_W +: TREE_W] <= TREE_W'(in_data[gi*DATA_W +: DATA_W]);
      end
    end
  end

  for (genvar gk = 1; gk <= LEVELS; gk++) begin : g_lvl
    localparam int unsigned SRC = 2 * NUM_IN - 2 * (NUM_IN >> (gk - 1));
    localparam int unsigned DST = 2 * NUM_IN - 2 * (NUM_IN >> gk);
    for (genvar gi = 0; gi < (NUM_IN >> gk); gi++) begin : g_node
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tree[(DST+gi)*TREE_W +: TREE_W] <= '0;
        end else if (!w_stall) begin
          r_tree[(DST+gi)*TREE_W +: TREE_W] <= r_tree[(SRC+2*gi)*TREE_W +: TREE_W]
                                             + r_tree[(SRC+2*gi+1)*TREE_W +: TREE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_lst <= '0;
    end else if (!w_stall) begin
      r_vld <= {r_vld[LEVELS-1:0], in_valid};
      r_lst <= {r_lst[LEVELS-1:0], in_last};
    end
  end

  assign w_root = r_tree[ROOT*TREE_W +: TREE_W];

  always_comb begin
    w_add     = {1'b0, r_acc} + (OUT_W+1)'(w_root);
    w_ovf     = r_sticky | w_add[OUT_W];
    w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
`ifdef SUM_TREE_SAT_EN
    // Once the sticky is set the accumulator stays pinned at full scale until the frame ends.
    w_acc_nxt = w_ovf ? '1 : w_add[OUT_W-1:0];
`else
    w_acc_nxt = w_add[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sticky  <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (!w_stall) begin
      out_valid <= 1'b0;
      if (r_vld[LEVELS]) begin
        if (r_lst[LEVELS]) begin
          out_sum   <= w_acc_nxt;
          out_beats <= w_cnt_inc;
          out_ovf   <= w_ovf;
          out_valid <= 1'b1;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_sticky  <= 1'b0;
        end else begin
          r_acc    <= w_acc_nxt;
          r_cnt    <= w_cnt_inc;
          r_sticky <= w_ovf;
        end
      end
    end
  end

endmodule
